instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Sequential instruction encoder and loader; the producer-side counterpart of the CPU's opcode decoder.
- Accepts one symbolic instruction per handshake (class select plus fields), packs the 32-bit MIPS word with the same opcode map the decoder consumes, and writes it into instruction memory at an auto-incrementing word address.
- Sits between the test/boot loader and the instruction memory write port.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  load write pointer from base_i; aborts any pending second word.
- base_i  in  ADDR_W  start word address.
- valid_i  in  1  instruction request valid.
- ready_o  out  1  encoder can accept this cycle.
- op_sel_i  in  4  class: 0 R, 1 BLTZ, 2 J, 3 JAL, 4 BEQ, 5 BNE, 6 BLE, 7 ADDI, 8 SLTIU, 9 ORI, 10 LUI, 11 LW, 12 SW, 13 LI (pseudo); 14-15 illegal.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register/shift fields.
- funct_i  in  6  R-type function.
- imm_i  in  32  immediate; bits [15:0] for I-type, full width for LI.
- target_i  in  26  J/JAL target.
- we_o  out  1  imem write strobe.
- waddr_o  out  ADDR_W  imem write address.
- wdata_o  out  32  encoded word.
- err_o  out  1  one-cycle pulse on illegal request.
- wrap_o  out  1  sticky: pointer wrapped.
- count_o  out  ADDR_W+1  words written since reset/start.

Behaviour:
- Reset (async, rst_i=0): state IDLE, ready_o=1, we_o=0, waddr_o=0, wdata_o=0, err_o=0, wrap_o=0, count_o=0, internal pointer=0.
- Opcodes: R 0, BLTZ 1, J 2, JAL 3, BEQ 4, BNE 5, BLE 6, ADDI 8, SLTIU 9, ORI 13, LUI 15, LW 35, SW 43.
- Formats:
  - R = {0, rs, rt, rd, shamt, funct}.
  - I = {op, rs, rt, imm[15:0]}.
  - J = {op, target}.
  - BLTZ forces rt=0; LUI forces rs=0. No sign/zero extension is applied; the raw 16 bits are packed.
- Handshake: transfer when valid_i && ready_o. Registered outputs; the word appears on we_o/waddr_o/wdata_o the cycle after acceptance (latency 1), we_o high exactly one cycle per word.
- Throughput: one single-word instruction per cycle back-to-back.
- FSM states:
  - IDLE: no write this cycle.
  - EMIT: writing word; ready_o=1 unless a second word is pending.
  - EMIT2: writing the second word of a pseudo; ready_o=1.
  - Transitions: IDLE/EMIT/EMIT2 -> EMIT on accept; -> IDLE when no accept.
- Pointer: increments by 1 after each written word; wraps 2^ADDR_W-1 -> 0, setting wrap_o (cleared only by reset or start_i).
- count_o saturates at 2^(ADDR_W+1)-1.
- Illegal op_sel (14, 15, or 13 without macro): consumed, no write, err_o=1 next cycle, pointer unchanged.
- start_i has priority over a same-cycle valid_i:
  - Request is not accepted (ready_o forced 0 that cycle).
  - Pointer:=base_i, count_o:=0, wrap_o:=0, pending second word dropped.
- Reset mid-pseudo discards the second word.

Optional Feature:
- Macro: INSTR_ENC_PSEUDO_EN.
- When defined, op_sel 13 (LI rt, imm32) is legal:
  - If imm_i[31:16]==0, emits one word: ORI rt,$0,imm[15:0].
  - Otherwise emits LUI rt,imm[31:16] then ORI rt,rt,imm[15:0] on consecutive cycles at consecutive addresses. ready_o=0 in the cycle the LUI is written.
- When undefined, op_sel 13 is illegal (err_o pulse) and EMIT2 is not built.

Decomposition:
- Shared package instr_pkg: opcode constants (OP_RTYPE=6'd0 through OP_SW=6'd43), op_sel enum values, field-position constants. The CPU decoder imports the same opcode constants.
- One natural sub-module, instr_pack: combinational field packer (op_sel plus fields -> 32-bit word, legality flag). The top holds the FSM, pointer, and counters.

Test Plan:
- Reset, then ADDI rs=1 rt=2 imm=0x0005 -> next cycle we_o=1, waddr_o=0, wdata_o=0x20220005.
- Back-to-back R (rs=1 rt=2 rd=3 funct=0x20) then SW (rs=29 rt=8 imm=4) -> words 0x00221820 at addr 0, 0xAFA80004 at addr 1 in consecutive cycles.
- start_i with base_i=0x3FF, then two J target=0x40 -> 0x08000040 at addr 0x3FF then addr 0; wrap_o=1.
- op_sel=15 -> no we_o, err_o one-cycle pulse, next legal word lands at the unchanged address.
- With INSTR_ENC_PSEUDO_EN, LI rt=4 imm=0x12345678 -> 0x3C041234 then 0x34845678; ready_o=0 during the first of the two.
- With INSTR_ENC_PSEUDO_EN, LI rt=4 imm=0x00000007 -> single word 0x34040007.
- Assert rst_i=0 mid-pseudo -> outputs return to reset values immediately; no ORI word is emitted.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared opcode map and field packing helpers for the instruction encoder.
// The CPU opcode decoder imports the same OP_* constants so both sides agree.
package instr_pkg;

  // Primary opcodes (bits [31:26] of the MIPS word)
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BLTZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLE   = 6'd6;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd9;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // Instruction class selector presented by the loader
  typedef enum logic [3:0] {
    SEL_R     = 4'd0,
    SEL_BLTZ  = 4'd1,
    SEL_J     = 4'd2,
    SEL_JAL   = 4'd3,
    SEL_BEQ   = 4'd4,
    SEL_BNE   = 4'd5,
    SEL_BLE   = 4'd6,
    SEL_ADDI  = 4'd7,
    SEL_SLTIU = 4'd8,
    SEL_ORI   = 4'd9,
    SEL_LUI   = 4'd10,
    SEL_LW    = 4'd11,
    SEL_SW    = 4'd12,
    SEL_LI    = 4'd13
  } op_sel_e;

  // Field positions inside the 32-bit word
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
           (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | 32'(funct);
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm16);
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] target);
    return (32'(op) << OP_LSB) | 32'(target);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-to-encoder request bus plus the encoder's imem write and status outputs.
// master = test/boot loader side, slave = instr_encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              start_i;
  logic [ADDR_W-1:0] base_i;
  logic              valid_i;
  logic              ready_o;
  logic [3:0]        op_sel_i;
  logic [4:0]        rs_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic [4:0]        shamt_i;
  logic [5:0]        funct_i;
  logic [31:0]       imm_i;
  logic [25:0]       target_i;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [31:0]       wdata_o;
  logic              err_o;
  logic              wrap_o;
  logic [ADDR_W:0]   count_o;

  modport master (
    output start_i, base_i, valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i,
           funct_i, imm_i, target_i,
    input  ready_o, we_o, waddr_o, wdata_o, err_o, wrap_o, count_o
  );

  modport slave (
    input  start_i, base_i, valid_i, op_sel_i, rs_i, rt_i, rd_i, shamt_i,
           funct_i, imm_i, target_i,
    output ready_o, we_o, waddr_o, wdata_o, err_o, wrap_o, count_o
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational field packer: class select + fields -> 32-bit MIPS word.
// Optional macro INSTR_ENC_PSEUDO_EN enables LI (one or two words).
module instr_pack
  import instr_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic [31:0] word2,
  output logic        legal,
  output logic        two_word
);

`ifndef INSTR_ENC_PSEUDO_EN
  // Upper immediate half only matters for LI, which is absent in this build
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:16];
`endif

  // Select format and opcode; BLTZ forces rt=0 and LUI forces rs=0
  always_comb begin
    word     = '0;
    word2    = '0;
    legal    = 1'b1;
    two_word = 1'b0;
    case (op_sel)
      SEL_R:     word = pack_r(rs, rt, rd, shamt, funct);
      SEL_BLTZ:  word = pack_i(OP_BLTZ, rs, 5'd0, imm[15:0]);
      SEL_J:     word = pack_j(OP_J, target);
      SEL_JAL:   word = pack_j(OP_JAL, target);
      SEL_BEQ:   word = pack_i(OP_BEQ, rs, rt, imm[15:0]);
      SEL_BNE:   word = pack_i(OP_BNE, rs, rt, imm[15:0]);
      SEL_BLE:   word = pack_i(OP_BLE, rs, rt, imm[15:0]);
      SEL_ADDI:  word = pack_i(OP_ADDI, rs, rt, imm[15:0]);
      SEL_SLTIU: word = pack_i(OP_SLTIU, rs, rt, imm[15:0]);
      SEL_ORI:   word = pack_i(OP_ORI, rs, rt, imm[15:0]);
      SEL_LUI:   word = pack_i(OP_LUI, 5'd0, rt, imm[15:0]);
      SEL_LW:    word = pack_i(OP_LW, rs, rt, imm[15:0]);
      SEL_SW:    word = pack_i(OP_SW, rs, rt, imm[15:0]);
`ifdef INSTR_ENC_PSEUDO_EN
      SEL_LI: begin
        if (imm[31:16] == 16'd0) begin
          word = pack_i(OP_ORI, 5'd0, rt, imm[15:0]);
        end else begin
          word     = pack_i(OP_LUI, 5'd0, rt, imm[31:16]);
          word2    = pack_i(OP_ORI, rt, rt, imm[15:0]);
          two_word = 1'b1;
        end
      end
`endif
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder/loader: packs one symbolic instruction per
// handshake and writes it to instruction memory at an auto-incrementing address.
// Optional macro INSTR_ENC_PSEUDO_EN adds the LI pseudo-op and the EMIT2 state.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic            clk_i,
  input logic            rst_i,
  instr_encoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
`ifdef INSTR_ENC_PSEUDO_EN
  localparam logic [1:0] ST_EMIT2 = 2'd2;
`endif

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic              err_reg, err_next;
  logic              wrap_reg, wrap_next;
  logic [ADDR_W:0]   count_reg, count_next;

  logic [31:0] pack_word, pack_word2;
  logic        pack_legal, pack_two;
  logic        ready, accept, pend_active, do_write;
  logic [31:0] write_word;

  instr_pack u_pack (
    .op_sel   (bus.op_sel_i),
    .rs       (bus.rs_i),
    .rt       (bus.rt_i),
    .rd       (bus.rd_i),
    .shamt    (bus.shamt_i),
    .funct    (bus.funct_i),
    .imm      (bus.imm_i),
    .target   (bus.target_i),
    .word     (pack_word),
    .word2    (pack_word2),
    .legal    (pack_legal),
    .two_word (pack_two)
  );

`ifdef INSTR_ENC_PSEUDO_EN
  logic        pend_reg, pend_next;
  logic [31:0] pend_word_reg, pend_word_next;

  // A second word is owed while the LUI half of an LI is on the bus
  assign pend_active = (state_reg == ST_EMIT) && pend_reg;

  // Second-word holding register for LI
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_reg      <= 1'b0;
      pend_word_reg <= '0;
    end else begin
      pend_reg      <= pend_next;
      pend_word_reg <= pend_word_next;
    end
  end
`else
  // Without pseudo-ops nothing is ever owed; state is kept for observability only
  assign pend_active = 1'b0;
  logic unused_state;
  assign unused_state = pack_two ^ (^pack_word2) ^ (^state_reg);
`endif

  // start_i blocks acceptance so the pointer reload never races a write
  assign ready  = !bus.start_i && !pend_active;
  assign accept = bus.valid_i && ready;

  // Next-state: start reload, owed second word, or a fresh request
  always_comb begin
    state_next = ST_IDLE;
    ptr_next   = ptr_reg;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    we_next    = 1'b0;
    err_next   = 1'b0;
    wrap_next  = wrap_reg;
    count_next = count_reg;
    do_write   = 1'b0;
    write_word = pack_word;
`ifdef INSTR_ENC_PSEUDO_EN
    pend_next      = 1'b0;
    pend_word_next = pend_word_reg;
`endif
    if (bus.start_i) begin
      ptr_next   = bus.base_i;
      count_next = '0;
      wrap_next  = 1'b0;
    end
`ifdef INSTR_ENC_PSEUDO_EN
    else if (pend_active) begin
      do_write   = 1'b1;
      write_word = pend_word_reg;
      state_next = ST_EMIT2;
    end
`endif
    else if (accept) begin
      if (pack_legal) begin
        do_write   = 1'b1;
        state_next = ST_EMIT;
`ifdef INSTR_ENC_PSEUDO_EN
        pend_next      = pack_two;
        pend_word_next = pack_word2;
`endif
      end else begin
        err_next = 1'b1;
      end
    end

    if (do_write) begin
      we_next    = 1'b1;
      waddr_next = ptr_reg;
      wdata_next = write_word;
      ptr_next   = ptr_reg + ADDR_W'(1);
      if (ptr_reg == '1) begin
        wrap_next = 1'b1;
      end
      if (count_reg != '1) begin
        count_next = count_reg + (ADDR_W+1)'(1);
      end
    end
  end

  // State, pointer and registered write-port outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      err_reg   <= err_next;
      wrap_reg  <= wrap_next;
      count_reg <= count_next;
    end
  end

  assign bus.ready_o = ready;
  assign bus.we_o    = we_reg;
  assign bus.waddr_o = waddr_reg;
  assign bus.wdata_o = wdata_reg;
  assign bus.err_o   = err_reg;
  assign bus.wrap_o  = wrap_reg;
  assign bus.count_o = count_reg;

endmodule
